// File: rtl/mem_bus_pkg.sv
// Shared types and defaults for the memory bus controller and its wait/timeout counters.
package mem_bus_pkg;

  localparam int DATA_W       = 16;
  localparam int CNT_W        = 4;
  localparam int WAIT_MIN_DEF = 1;
  localparam int TIMEOUT_DEF  = 15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } bus_state_e;

endpackage

// File: rtl/mem_wait_timer.sv
// Loadable 4-bit counter: counts down to zero (wait mode) or up to TERM (timeout mode).
module mem_wait_timer #(
  parameter int             W    = 4,
  parameter bit             DOWN = 1'b1,
  parameter logic [W-1:0]   TERM = '0
) (
  input  logic         gclk,
  input  logic         grst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         flag
);

  logic [W-1:0] cnt;

  // Both directions saturate so a stray enable can never wrap the count.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n)   cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en) begin
      if (DOWN && cnt != '0)       cnt <= cnt - 1'b1;
      else if (!DOWN && cnt != '1) cnt <= cnt + 1'b1;
    end
  end

  assign flag = DOWN ? (cnt == '0) : (cnt == TERM);

endmodule

// File: rtl/mem_bus_ctrl.sv
// Single-outstanding memory bus controller: IDLE -> SETUP -> ACCESS -> DONE with
// minimum-wait and timeout handling; faulty requests skip the access and report err.
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int WAIT_MIN = WAIT_MIN_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic [DATA_W-1:0] MAR_in,
  input  logic [DATA_W-1:0] MDR_wdata,
  input  logic              rd_req,
  input  logic              wr_req,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              ld_mdr,
  output logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ce,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam logic [CNT_W-1:0] WAIT_LD  = CNT_W'(WAIT_MIN);
  localparam logic [CNT_W-1:0] TMO_TERM = CNT_W'(TIMEOUT - 1);

  bus_state_e state_q, state_d;
  logic       req_wr_q, req_fault_q;
  logic       accept, cnt_load, cnt_en;
  logic       wait_zero, tmo_term, complete;

  assign busy     = (state_q != IDLE);
  assign accept   = (state_q == IDLE) && (rd_req || wr_req);
  assign cnt_load = (state_q == SETUP) && !req_fault_q;
  assign cnt_en   = (state_q == ACCESS);
  // Completion wins over a timeout landing on the same edge.
  assign complete = (state_q == ACCESS) && wait_zero && mem_ready;

  mem_wait_timer #(.W(CNT_W), .DOWN(1'b1), .TERM('0)) u_wait (
    .gclk     (CLK),
    .grst_n   (CLR),
    .load     (cnt_load),
    .load_val (WAIT_LD),
    .en       (cnt_en),
    .flag     (wait_zero)
  );

  mem_wait_timer #(.W(CNT_W), .DOWN(1'b0), .TERM(TMO_TERM)) u_tmo (
    .gclk     (CLK),
    .grst_n   (CLR),
    .load     (cnt_load),
    .load_val ('0),
    .en       (cnt_en),
    .flag     (tmo_term)
  );

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SETUP;
      SETUP:   state_d = req_fault_q ? DONE : ACCESS;
      ACCESS:  if (complete || tmo_term) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      req_wr_q    <= 1'b0;
      req_fault_q <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      ld_mdr      <= 1'b0;
      rdata       <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_ce      <= 1'b0;
      mem_we      <= 1'b0;
    end else begin
      done   <= 1'b0;
      ld_mdr <= 1'b0;
      case (state_q)
        IDLE: if (accept) begin
          // Dual request or odd address is flagged here and never reaches the bus.
          req_wr_q    <= wr_req;
          req_fault_q <= (rd_req && wr_req) || MAR_in[0];
          mem_addr    <= MAR_in;
          mem_wdata   <= MDR_wdata;
          mem_ce      <= !((rd_req && wr_req) || MAR_in[0]);
          mem_we      <= wr_req && !rd_req && !MAR_in[0];
          err         <= 1'b0;
        end
        SETUP: if (req_fault_q) begin
          done <= 1'b1;
          err  <= 1'b1;
        end
        ACCESS: if (complete || tmo_term) begin
          done   <= 1'b1;
          err    <= !complete;
          ld_mdr <= complete && !req_wr_q;
          mem_ce <= 1'b0;
          mem_we <= 1'b0;
          if (complete && !req_wr_q) rdata <= mem_rdata;
        end
        default: ;
      endcase
    end
  end

endmodule
